// File: rtl/branch_predict_unit.sv
// IF-stage BTB branch predictor with 2-bit counters and MEM-stage mispredict resolver/trainer.
// Optional BPU_STATS_EN adds saturating branch/mispredict counters on Stat_Branches/Stat_Mispredicts.
module branch_predict_unit #(
    parameter int unsigned INDEX_BITS = 4,
    parameter logic [1:0]  CTR_INIT   = 2'b01
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] IF_PC,
    output logic        IF_PredTaken,
    output logic [31:0] IF_PredTarget,
    input  logic [1:0]  MEM_BranchType,
    input  logic        Branch,
    input  logic [31:0] MEM_PC,
    input  logic [31:0] MEM_BranchTarget,
    input  logic        MEM_PredTaken,
    input  logic [31:0] MEM_PredTarget,
    output logic        Mispredict,
    output logic [31:0] Redirect_PC,
    output logic        Flush
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] Stat_Branches,
    output logic [31:0] Stat_Mispredicts
`endif
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = 32 - INDEX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, mem_idx;
    logic [TAG_W-1:0]      if_tag, mem_tag;
    logic                  if_hit, mem_hit, resolve;
    logic                  upd_we;
    logic [1:0]            ctr_d;
    logic [31:0]           target_d;
    logic                  unused_pc_lsbs;

    assign if_idx  = IF_PC[INDEX_BITS+1:2];
    assign if_tag  = IF_PC[31:INDEX_BITS+2];
    assign mem_idx = MEM_PC[INDEX_BITS+1:2];
    assign mem_tag = MEM_PC[31:INDEX_BITS+2];
    assign unused_pc_lsbs = ^{IF_PC[1:0], MEM_PC[1:0]};

    // Fetch-side lookup; reads pre-edge table contents, no bypass from the update path.
    always_comb begin
        if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        IF_PredTaken  = !Reset && if_hit && ctr_q[if_idx][1];
        IF_PredTarget = IF_PredTaken ? target_q[if_idx] : IF_PC + 32'd4;
    end

    // MEM-side resolution; everything is forced quiet during reset or non-branch cycles.
    always_comb begin
        resolve     = !Reset && (MEM_BranchType != 2'b00);
        mem_hit     = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);
        Mispredict  = resolve && ((Branch != MEM_PredTaken) ||
                                  (Branch && (MEM_PredTarget != MEM_BranchTarget)));
        Flush       = Mispredict;
        Redirect_PC = 32'd0;
        if (resolve) begin
            Redirect_PC = Branch ? MEM_BranchTarget : MEM_PC + 32'd4;
        end
    end

    // Next-state for the entry addressed by MEM_PC.
    always_comb begin
        upd_we   = 1'b0;
        ctr_d    = ctr_q[mem_idx];
        target_d = target_q[mem_idx];
        if (resolve) begin
            if (mem_hit) begin
                upd_we = 1'b1;
                if (Branch) begin
                    ctr_d    = (ctr_q[mem_idx] == 2'b11) ? 2'b11 : ctr_q[mem_idx] + 2'd1;
                    target_d = MEM_BranchTarget;
                end else begin
                    ctr_d = (ctr_q[mem_idx] == 2'b00) ? 2'b00 : ctr_q[mem_idx] - 2'd1;
                end
            end else if (Branch) begin
                upd_we   = 1'b1;
                ctr_d    = 2'b10;
                target_d = MEM_BranchTarget;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (upd_we) begin
            valid_q[mem_idx] <= 1'b1;
            ctr_q[mem_idx]   <= ctr_d;
        end
    end

    // Tag and target carry no reset value; valid gates their use.
    always_ff @(posedge CLK) begin
        if (upd_we) begin
            tag_q[mem_idx]    <= mem_tag;
            target_q[mem_idx] <= target_d;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            if (resolve && (stat_br_q != 32'hFFFF_FFFF)) stat_br_q <= stat_br_q + 32'd1;
            if (Mispredict && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign Stat_Branches    = stat_br_q;
    assign Stat_Mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: hand-computed lookup, resolve and training checks.
module tb_branch_predict_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] IF_PC;
    logic        IF_PredTaken;
    logic [31:0] IF_PredTarget;
    logic [1:0]  MEM_BranchType;
    logic        Branch;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_BranchTarget;
    logic        MEM_PredTaken;
    logic [31:0] MEM_PredTarget;
    logic        Mispredict;
    logic [31:0] Redirect_PC;
    logic        Flush;
`ifdef BPU_STATS_EN
    logic [31:0] Stat_Branches;
    logic [31:0] Stat_Mispredicts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    branch_predict_unit dut (
        .CLK             (CLK),
        .Reset           (Reset),
        .IF_PC           (IF_PC),
        .IF_PredTaken    (IF_PredTaken),
        .IF_PredTarget   (IF_PredTarget),
        .MEM_BranchType  (MEM_BranchType),
        .Branch          (Branch),
        .MEM_PC          (MEM_PC),
        .MEM_BranchTarget(MEM_BranchTarget),
        .MEM_PredTaken   (MEM_PredTaken),
        .MEM_PredTarget  (MEM_PredTarget),
        .Mispredict      (Mispredict),
        .Redirect_PC     (Redirect_PC),
        .Flush           (Flush)
`ifdef BPU_STATS_EN
        ,
        .Stat_Branches   (Stat_Branches),
        .Stat_Mispredicts(Stat_Mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic mem(input logic [1:0] bt, input logic br, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        MEM_BranchType   = bt;
        Branch           = br;
        MEM_PC           = pc;
        MEM_BranchTarget = tgt;
        MEM_PredTaken    = ptk;
        MEM_PredTarget   = ptgt;
        #1;
    endtask

    task automatic idle();
        mem(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt);
        IF_PC = pc;
        #1;
        check({tag, ".taken"}, 32'(IF_PredTaken), 32'(tk));
        check({tag, ".target"}, IF_PredTarget, tgt);
    endtask

    task automatic resolved(input string tag, input logic mp, input logic [31:0] rpc);
        check({tag, ".mispredict"}, 32'(Mispredict), 32'(mp));
        check({tag, ".flush"}, 32'(Flush), 32'(mp));
        check({tag, ".redirect"}, Redirect_PC, rpc);
    endtask

    initial begin
        Reset = 1'b1;
        IF_PC = 32'h0;
        idle();
        step();
        step();

        // Outputs held quiet while reset is asserted, even with a live taken branch.
        mem(2'b01, 1'b1, 32'h0040_0020, 32'h0040_0100, 1'b0, 32'h0040_0024);
        resolved("rst_quiet", 1'b0, 32'h0);
        look("rst_look", 32'h0040_0010, 1'b0, 32'h0040_0014);
        step();
        Reset = 1'b0;
        idle();

        // Cold lookup and not-taken resolve (no allocation).
        look("cold", 32'h0040_0010, 1'b0, 32'h0040_0014);
        mem(2'b01, 1'b0, 32'h0040_0010, 32'h0040_0080, 1'b0, 32'h0040_0014);
        resolved("nt_cold", 1'b0, 32'h0040_0014);
        step();
        idle();
        look("nt_noalloc", 32'h0040_0010, 1'b0, 32'h0040_0014);

        // Cold taken: allocate; same-cycle lookup still misses.
        mem(2'b10, 1'b1, 32'h0040_0020, 32'h0040_0100, 1'b0, 32'h0040_0024);
        resolved("cold_taken", 1'b1, 32'h0040_0100);
        look("same_cycle", 32'h0040_0020, 1'b0, 32'h0040_0024);
        step();
        idle();
        look("alloc", 32'h0040_0020, 1'b1, 32'h0040_0100);

        // Three correctly predicted taken resolutions saturate ctr at 11.
        for (int i = 0; i < 3; i++) begin
            mem(2'b01, 1'b1, 32'h0040_0020, 32'h0040_0100, 1'b1, 32'h0040_0100);
            resolved("correct", 1'b0, 32'h0040_0100);
            step();
        end
        // 11 -> 10: still taken.
        mem(2'b01, 1'b0, 32'h0040_0020, 32'h0040_0100, 1'b1, 32'h0040_0100);
        resolved("nt1", 1'b1, 32'h0040_0024);
        step();
        idle();
        look("after_nt1", 32'h0040_0020, 1'b1, 32'h0040_0100);
        // 10 -> 01: not taken.
        mem(2'b01, 1'b0, 32'h0040_0020, 32'h0040_0100, 1'b1, 32'h0040_0100);
        resolved("nt2", 1'b1, 32'h0040_0024);
        step();
        idle();
        look("after_nt2", 32'h0040_0020, 1'b0, 32'h0040_0024);

        // Target mismatch: 01 -> 10 and target retrained.
        mem(2'b11, 1'b1, 32'h0040_0020, 32'h0040_0200, 1'b1, 32'h0040_0100);
        resolved("tgt_mismatch", 1'b1, 32'h0040_0200);
        step();
        idle();
        look("retarget", 32'h0040_0020, 1'b1, 32'h0040_0200);

        // Aliasing on index 8: different tag misses; not-taken leaves the resident entry.
        look("alias_miss", 32'h0040_0420, 1'b0, 32'h0040_0424);
        mem(2'b01, 1'b0, 32'h0040_0420, 32'h0040_0500, 1'b0, 32'h0040_0424);
        resolved("alias_nt", 1'b0, 32'h0040_0424);
        step();
        idle();
        look("alias_keep", 32'h0040_0020, 1'b1, 32'h0040_0200);
        mem(2'b01, 1'b1, 32'h0040_0420, 32'h0040_0500, 1'b0, 32'h0040_0424);
        resolved("alias_taken", 1'b1, 32'h0040_0500);
        step();
        idle();
        look("evicted", 32'h0040_0020, 1'b0, 32'h0040_0024);
        look("alias_hit", 32'h0040_0420, 1'b1, 32'h0040_0500);

        // Wraparound of PC+4 on both sides.
        look("if_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        mem(2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 32'h0000_1000);
        resolved("mem_wrap", 1'b1, 32'h0000_0000);

        // No resolve: MEM outputs zero even with Branch set.
        mem(2'b00, 1'b1, 32'h0040_0020, 32'h0040_0100, 1'b0, 32'h0040_0024);
        resolved("no_resolve", 1'b0, 32'h0);
        step();
        idle();
        look("no_resolve_nowrite", 32'h0040_0020, 1'b0, 32'h0040_0024);

        // Reset during a taken resolve: update discarded and table cleared.
        mem(2'b01, 1'b1, 32'h0040_0040, 32'h0040_0300, 1'b0, 32'h0040_0044);
        Reset = 1'b1;
        #1;
        resolved("rst_resolve", 1'b0, 32'h0);
        step();
        Reset = 1'b0;
        idle();
        look("cleared", 32'h0040_0420, 1'b0, 32'h0040_0424);
        look("discarded", 32'h0040_0040, 1'b0, 32'h0040_0044);
`ifdef BPU_STATS_EN
        check("stat_br_rst", Stat_Branches, 32'd0);
        check("stat_mp_rst", Stat_Mispredicts, 32'd0);
`endif

        // Five resolves, two mispredicts, plus one non-branch cycle.
        mem(2'b01, 1'b1, 32'h0040_0060, 32'h0040_0600, 1'b0, 32'h0040_0064);
        resolved("s1", 1'b1, 32'h0040_0600);
        step();
        mem(2'b10, 1'b1, 32'h0040_0060, 32'h0040_0600, 1'b1, 32'h0040_0600);
        resolved("s2", 1'b0, 32'h0040_0600);
        step();
        mem(2'b01, 1'b0, 32'h0040_0070, 32'h0040_0700, 1'b0, 32'h0040_0074);
        resolved("s3", 1'b0, 32'h0040_0074);
        step();
        idle();
        step();
        mem(2'b01, 1'b0, 32'h0040_0060, 32'h0040_0600, 1'b1, 32'h0040_0600);
        resolved("s4", 1'b1, 32'h0040_0064);
        step();
        mem(2'b11, 1'b1, 32'h0040_0060, 32'h0040_0600, 1'b1, 32'h0040_0600);
        resolved("s5", 1'b0, 32'h0040_0600);
        step();
        idle();
        // ctr: 10 -> 11 -> 10 -> 11
        look("stats_seq", 32'h0040_0060, 1'b1, 32'h0040_0600);
`ifdef BPU_STATS_EN
        check("stat_br", Stat_Branches, 32'd5);
        check("stat_mp", Stat_Mispredicts, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
